// File: rtl/bin2bcd_seq_pkg.sv
// Shared display codes, FSM state type and digit helpers for bin2bcd_seq.
package bin2bcd_seq_pkg;

  typedef bit [3:0] bcd_digit_t;

  localparam bcd_digit_t MINUS = 4'hA;
  localparam bcd_digit_t EMPTY = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS,
    S_SHIFT,
    S_FORMAT,
    S_DONE
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int clog10(input longint value);
    int     result;
    longint power;
    result = 0;
    power  = 1;
    while (power < value) begin
      power  = power * 10;
      result++;
    end
    return result;
  endfunction

  // Double-dabble correction: a digit of 5 or more would overflow past 9 after doubling.
  function automatic bcd_digit_t bcd_add3(input bcd_digit_t digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_blank.sv
// Leading-zero blanking formatter for bin2bcd_seq; only built when BIN2BCD_BLANK_EN is defined.
`ifdef BIN2BCD_BLANK_EN
module bcd_blank
  import bin2bcd_seq_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int SIGNED = 1
) (
  input  logic [4*(DIGITS-SIGNED)-1:0] i_digits,
  input  logic                         i_sign,
  input  logic                         i_ovf,
  output logic [4*DIGITS-1:0]          o_bcd
);

  localparam int MAG = DIGITS - SIGNED;

  int w_msd;

  // The minus sign floats just above the most significant non-zero digit; slot 0 is never blanked.
  always_comb begin
    w_msd = 0;
    for (int i = 0; i < MAG; i++) begin
      if (i_digits[4*i +: 4] != 4'd0) w_msd = i;
    end
    o_bcd = {DIGITS{EMPTY}};
    if (i_ovf) begin
      for (int i = 0; i < MAG; i++) o_bcd[4*i +: 4] = 4'h9;
      if ((SIGNED != 0) && i_sign) o_bcd[4*(DIGITS-1) +: 4] = MINUS;
    end else begin
      for (int i = 0; i < MAG; i++) begin
        if (i <= w_msd) o_bcd[4*i +: 4] = i_digits[4*i +: 4];
      end
      if ((SIGNED != 0) && i_sign) o_bcd[4*(w_msd+1) +: 4] = MINUS;
    end
  end

endmodule
`endif

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-display-BCD converter with sign, saturation and handshakes.
// Define BIN2BCD_BLANK_EN to blank leading zeros and float the minus sign next to the digits.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 6,
  parameter int SIGNED    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_WIDTH-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_overflow
);

  localparam int MAG   = DIGITS - SIGNED;
  localparam int CNT_W = clog2(BIN_WIDTH);

  if (DIGITS < SIGNED + 1) begin : g_badDigits
    $error("bin2bcd_seq: DIGITS must leave at least one magnitude slot");
  end
  if (BIN_WIDTH < 2 || BIN_WIDTH > 32 || DIGITS < 2 || DIGITS > 8) begin : g_badRange
    $error("bin2bcd_seq: BIN_WIDTH must be 2..32 and DIGITS 2..8");
  end

  state_t               r_state;
  state_t               w_nextState;
  logic [BIN_WIDTH-1:0] r_mag;
  logic [4*MAG-1:0]     r_digits;
  logic [4*MAG-1:0]     w_adjDigits;
  logic                 r_sign;
  logic                 r_ovf;
  logic [CNT_W-1:0]     r_bitCount;
  logic [4*DIGITS-1:0]  w_formatted;
  logic [4*DIGITS-1:0]  r_outBcd;
  logic                 r_outOverflow;
  logic                 w_neg;

  assign w_neg        = (SIGNED != 0) && r_mag[BIN_WIDTH-1];
  assign in_ready     = (r_state == S_IDLE);
  assign out_valid    = (r_state == S_DONE);
  assign out_bcd      = r_outBcd;
  assign out_overflow = r_outOverflow;

  always_comb begin
    w_adjDigits = '0;
    for (int i = 0; i < MAG; i++) w_adjDigits[4*i +: 4] = bcd_add3(r_digits[4*i +: 4]);
  end

`ifdef BIN2BCD_BLANK_EN
  bcd_blank #(
    .DIGITS (DIGITS),
    .SIGNED (SIGNED)
  ) u_blank (
    .i_digits (r_digits),
    .i_sign   (r_sign),
    .i_ovf    (r_ovf),
    .o_bcd    (w_formatted)
  );
`else
  always_comb begin
    w_formatted            = {DIGITS{EMPTY}};
    w_formatted[4*MAG-1:0] = r_ovf ? {MAG{4'h9}} : r_digits;
    if ((SIGNED != 0) && r_sign) w_formatted[4*DIGITS-1 -: 4] = MINUS;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_nextState = S_ABS;
      S_ABS:    w_nextState = S_SHIFT;
      S_SHIFT:  if (r_bitCount == '0) w_nextState = S_FORMAT;
      S_FORMAT: w_nextState = S_DONE;
      S_DONE:   if (out_ready) w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // Overflow is caught when a set MSB in the top digit is about to be shifted out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag         <= '0;
      r_digits      <= '0;
      r_sign        <= 1'b0;
      r_ovf         <= 1'b0;
      r_bitCount    <= '0;
      r_outBcd      <= {DIGITS{EMPTY}};
      r_outOverflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) r_mag <= in_data;
        end
        S_ABS: begin
          r_sign     <= w_neg;
          if (w_neg) r_mag <= -r_mag;
          r_digits   <= '0;
          r_ovf      <= 1'b0;
          r_bitCount <= CNT_W'(BIN_WIDTH - 1);
        end
        S_SHIFT: begin
          r_digits   <= {w_adjDigits[4*MAG-2:0], r_mag[BIN_WIDTH-1]};
          r_mag      <= {r_mag[BIN_WIDTH-2:0], 1'b0};
          r_ovf      <= r_ovf | w_adjDigits[4*MAG-1];
          r_bitCount <= r_bitCount - CNT_W'(1);
        end
        S_FORMAT: begin
          r_outBcd      <= w_formatted;
          r_outOverflow <= r_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomised self-checking bench for bin2bcd_seq against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rstN;
  logic        inValid, inReady, outValid, outReady, outOverflow;
  logic [15:0] inData;
  logic [23:0] outBcd;
  logic        inValid2, outReady2;
  logic [15:0] inData2;
  logic        inReadyS, outValidS, outOvfS;
  logic        inReadyU, outValidU, outOvfU;
  logic [15:0] outBcdS, outBcdU;

  int nCompared;
  int nMismatched;

  bin2bcd_seq #(.BIN_WIDTH(16), .DIGITS(6), .SIGNED(1)) dut (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady), .in_data(inData),
    .out_valid(outValid), .out_ready(outReady), .out_bcd(outBcd), .out_overflow(outOverflow)
  );

  bin2bcd_seq #(.BIN_WIDTH(16), .DIGITS(4), .SIGNED(1)) dutSmall (
    .clk(clk), .rst_n(rstN), .in_valid(inValid2), .in_ready(inReadyS), .in_data(inData2),
    .out_valid(outValidS), .out_ready(outReady2), .out_bcd(outBcdS), .out_overflow(outOvfS)
  );

  bin2bcd_seq #(.BIN_WIDTH(16), .DIGITS(4), .SIGNED(0)) dutUns (
    .clk(clk), .rst_n(rstN), .in_valid(inValid2), .in_ready(inReadyU), .in_data(inData2),
    .out_valid(outValidU), .out_ready(outReady2), .out_bcd(outBcdU), .out_overflow(outOvfU)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected display from plain decimal arithmetic on the 16-bit input value.
  function automatic logic [31:0] modelBcd(input logic [15:0] x, input int digits,
                                           input int isSigned, output logic ovf);
    logic [31:0] res;
    longint      mag, limit, pw;
    int          magSlots, msd;
    int          dec[8];
    logic        neg;
    magSlots = digits - isSigned;
    neg      = (isSigned != 0) && x[15];
    mag      = neg ? (65536 - longint'(x)) : longint'(x);
    limit    = 1;
    for (int i = 0; i < magSlots; i++) limit = limit * 10;
    ovf = (mag >= limit);
    res = '0;
    for (int i = 0; i < digits; i++) res[4*i +: 4] = 4'hF;
    if (ovf) begin
      for (int i = 0; i < magSlots; i++) res[4*i +: 4] = 4'h9;
      if (neg) res[4*(digits-1) +: 4] = 4'hA;
    end else begin
      msd = 0;
      pw  = 1;
      for (int i = 0; i < 8; i++) dec[i] = 0;
      for (int i = 0; i < magSlots; i++) begin
        dec[i] = int'((mag / pw) % 10);
        if (dec[i] != 0) msd = i;
        pw = pw * 10;
      end
`ifdef BIN2BCD_BLANK_EN
      for (int i = 0; i <= msd; i++) res[4*i +: 4] = 4'(dec[i]);
      if (neg) res[4*(msd+1) +: 4] = 4'hA;
`else
      for (int i = 0; i < magSlots; i++) res[4*i +: 4] = 4'(dec[i]);
      if (neg) res[4*(digits-1) +: 4] = 4'hA;
`endif
    end
    return res;
  endfunction

  // Cycle 1 is the first cycle after the accept edge; lat is the cycle where out_valid is seen.
  task automatic doConvert(input logic [15:0] val, output logic [23:0] bcd,
                           output logic ovf, output int lat);
    inData  = val;
    inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    lat     = 1;
    while (outValid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    bcd      = outBcd;
    ovf      = outOverflow;
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
  endtask

  task automatic doConvert2(input logic [15:0] val, output logic [15:0] bcdS, output logic ovfS,
                            output logic [15:0] bcdU, output logic ovfU, output int lat);
    inData2  = val;
    inValid2 = 1'b1;
    @(posedge clk); #1;
    inValid2 = 1'b0;
    lat      = 1;
    while (!(outValidS === 1'b1 && outValidU === 1'b1) && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    bcdS      = outBcdS;
    ovfS      = outOvfS;
    bcdU      = outBcdU;
    ovfU      = outOvfU;
    outReady2 = 1'b1;
    @(posedge clk); #1;
    outReady2 = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b1;
    #3 rstN = 1'b0;
    @(posedge clk); #1;
    nCompared++; if (inReady !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_in_ready got %b want 1", inReady); end
    nCompared++; if (outValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_out_valid got %b want 0", outValid); end
    nCompared++; if (outBcd !== 24'hFFFFFF) begin nMismatched++; $display("[TB] FAIL reset_out_bcd got %h want ffffff", outBcd); end
    nCompared++; if (outOverflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_overflow got %b want 0", outOverflow); end
    nCompared++; if (outBcdS !== 16'hFFFF) begin nMismatched++; $display("[TB] FAIL reset_small_bcd got %h want ffff", outBcdS); end
    rstN = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [15:0] vals[10] = '{16'd1234, 16'hFECF, 16'd0, 16'h8000, 16'd42,
                              16'h7FFF, 16'hFFFF, 16'd9, 16'd10, 16'd60000};
    logic [23:0] bcd;
    logic [31:0] expBcd;
    logic        ovf, expOvf;
    int          lat;
    foreach (vals[k]) begin
      doConvert(vals[k], bcd, ovf, lat);
      expBcd = modelBcd(vals[k], 6, 1, expOvf);
      nCompared++; if (bcd !== expBcd[23:0]) begin nMismatched++; $display("[TB] FAIL directed_bcd in=%h got %h want %h", vals[k], bcd, expBcd[23:0]); end
      nCompared++; if (ovf !== expOvf) begin nMismatched++; $display("[TB] FAIL directed_ovf in=%h got %b want %b", vals[k], ovf, expOvf); end
      nCompared++; if (lat !== 19) begin nMismatched++; $display("[TB] FAIL directed_latency in=%h got %0d want 19", vals[k], lat); end
    end
  endtask

  task automatic test_random();
    logic [15:0] val;
    logic [23:0] bcd;
    logic [31:0] expBcd;
    logic        ovf, expOvf;
    int          lat;
    for (int k = 0; k < 25; k++) begin
      val = 16'($urandom);
      doConvert(val, bcd, ovf, lat);
      expBcd = modelBcd(val, 6, 1, expOvf);
      nCompared++; if (bcd !== expBcd[23:0] || ovf !== expOvf || lat !== 19) begin
        nMismatched++;
        $display("[TB] FAIL random in=%h got %h/%b/%0d want %h/%b/19", val, bcd, ovf, lat, expBcd[23:0], expOvf);
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] vals[12];
    logic [15:0] bcdS, bcdU;
    logic [31:0] expS, expU;
    logic        ovfS, ovfU, expOvfS, expOvfU;
    int          lat;
    vals = '{16'd12345, 16'hCFC7, 16'd999, 16'hFC19, 16'd1000, 16'd9999,
             16'd10000, 16'hFC18, 16'd0, 16'h8000, 16'd500, 16'd65535};
    for (int k = 0; k < 18; k++) begin
      logic [15:0] v;
      v = (k < 12) ? vals[k] : 16'($urandom);
      doConvert2(v, bcdS, ovfS, bcdU, ovfU, lat);
      expS = modelBcd(v, 4, 1, expOvfS);
      expU = modelBcd(v, 4, 0, expOvfU);
      nCompared++; if (bcdS !== expS[15:0] || ovfS !== expOvfS) begin
        nMismatched++;
        $display("[TB] FAIL ovf_signed4 in=%h got %h/%b want %h/%b", v, bcdS, ovfS, expS[15:0], expOvfS);
      end
      nCompared++; if (bcdU !== expU[15:0] || ovfU !== expOvfU) begin
        nMismatched++;
        $display("[TB] FAIL ovf_unsigned4 in=%h got %h/%b want %h/%b", v, bcdU, ovfU, expU[15:0], expOvfU);
      end
      nCompared++; if (lat !== 19) begin nMismatched++; $display("[TB] FAIL ovf_latency in=%h got %0d want 19", v, lat); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] val;
    logic [31:0] expBcd;
    logic        expOvf;
    int          lat;
    bit          sawValid;
    val    = 16'($urandom);
    expBcd = modelBcd(val, 6, 1, expOvf);
    inData = val; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    inValid = 1'b1; inData = ~val; outReady = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0; outReady = 1'b0;
    nCompared++; if (inReady !== 1'b0) begin nMismatched++; $display("[TB] FAIL busy_in_ready got %b want 0", inReady); end
    lat = 0;
    while (outValid !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
    nCompared++; if (outValid !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_timeout out_valid got %b want 1", outValid); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      nCompared++; if (outValid !== 1'b1 || inReady !== 1'b0 || outBcd !== expBcd[23:0] || outOverflow !== expOvf) begin
        nMismatched++;
        $display("[TB] FAIL bp_hold cyc=%0d got v=%b r=%b %h/%b want v=1 r=0 %h/%b", c, outValid, inReady, outBcd, outOverflow, expBcd[23:0], expOvf);
      end
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    nCompared++; if (outValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_release_valid got %b want 0", outValid); end
    nCompared++; if (inReady !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_release_ready got %b want 1", inReady); end
    sawValid = 1'b0;
    repeat (25) begin @(posedge clk); #1; if (outValid === 1'b1) sawValid = 1'b1; end
    nCompared++; if (sawValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL ignored_pulse got extra result 1 want 0"); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] val;
    logic [23:0] bcd;
    logic [31:0] expBcd;
    logic        ovf, expOvf;
    int          lat;
    bit          sawValid;
    inData = 16'($urandom); inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rstN = 1'b0;
    #1;
    nCompared++; if (outValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL midreset_valid got %b want 0", outValid); end
    nCompared++; if (outBcd !== 24'hFFFFFF) begin nMismatched++; $display("[TB] FAIL midreset_bcd got %h want ffffff", outBcd); end
    nCompared++; if (inReady !== 1'b1) begin nMismatched++; $display("[TB] FAIL midreset_ready got %b want 1", inReady); end
    @(posedge clk); #1;
    rstN = 1'b1;
    sawValid = 1'b0;
    repeat (25) begin @(posedge clk); #1; if (outValid === 1'b1) sawValid = 1'b1; end
    nCompared++; if (sawValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL midreset_partial got result 1 want 0"); end
    val = 16'hFECF ^ 16'($urandom_range(0, 255));
    doConvert(val, bcd, ovf, lat);
    expBcd = modelBcd(val, 6, 1, expOvf);
    nCompared++; if (bcd !== expBcd[23:0] || ovf !== expOvf || lat !== 19) begin
      nMismatched++;
      $display("[TB] FAIL after_reset in=%h got %h/%b/%0d want %h/%b/19", val, bcd, ovf, lat, expBcd[23:0], expOvf);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b;
    logic [23:0] res[2];
    logic [31:0] expA, expB;
    logic        expOvf, prevReady;
    int          acc1, acc2, nRes;
    a = 16'($urandom); b = 16'($urandom);
    expA = modelBcd(a, 6, 1, expOvf);
    expB = modelBcd(b, 6, 1, expOvf);
    outReady = 1'b1; inData = a; inValid = 1'b1;
    acc1 = -1; acc2 = -1; nRes = 0;
    for (int cyc = 1; cyc <= 80 && nRes < 2; cyc++) begin
      prevReady = inReady;
      @(posedge clk); #1;
      if (prevReady && inValid) begin
        if (acc1 < 0) begin acc1 = cyc; inData = b; end
        else begin acc2 = cyc; inValid = 1'b0; end
      end
      if (outValid === 1'b1) begin res[nRes] = outBcd; nRes++; end
    end
    inValid = 1'b0; outReady = 1'b0;
    nCompared++; if (nRes !== 2) begin nMismatched++; $display("[TB] FAIL b2b_results got %0d want 2", nRes); end
    nCompared++; if (acc2 - acc1 !== 20) begin nMismatched++; $display("[TB] FAIL b2b_period got %0d want 20", acc2 - acc1); end
    nCompared++; if (res[0] !== expA[23:0]) begin nMismatched++; $display("[TB] FAIL b2b_first in=%h got %h want %h", a, res[0], expA[23:0]); end
    nCompared++; if (res[1] !== expB[23:0]) begin nMismatched++; $display("[TB] FAIL b2b_second in=%h got %h want %h", b, res[1], expB[23:0]); end
    @(posedge clk); #1;
  endtask

  initial begin
    nCompared = 0; nMismatched = 0;
    inValid = 1'b0; inData = '0; outReady = 1'b0;
    inValid2 = 1'b0; inData2 = '0; outReady2 = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
